// File: rtl/fpu_mc_if.sv
// fpu_mc_if: request/result handshake between a requester and the fpu_mc responder.
// The o_flags signal exists only when FPU_EXC_FLAGS_EN is defined.
interface fpu_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic [INST_WIDTH-1:0] i_inst;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
`ifdef FPU_EXC_FLAGS_EN
  logic [3:0]            o_flags;

  modport master (output i_data_a, i_data_b, i_inst, i_valid,
                  input  o_data, o_valid, o_flags);
  modport slave  (input  i_data_a, i_data_b, i_inst, i_valid,
                  output o_data, o_valid, o_flags);
`else
  modport master (output i_data_a, i_data_b, i_inst, i_valid,
                  input  o_data, o_valid);
  modport slave  (input  i_data_a, i_data_b, i_inst, i_valid,
                  output o_data, o_valid);
`endif
endinterface

// File: rtl/fpu_mc.sv
// fpu_mc: multi-cycle FP32 add/mul (RNE, denormals flushed), one operation in flight.
// Defining FPU_EXC_FLAGS_EN adds o_flags = {invalid, overflow, underflow, inexact}.
module fpu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 1
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  fpu_mc_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, NORM, ROUND, OUT} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [INST_WIDTH-1:0] inst_r;
  logic [47:0] mant_r;
  logic [9:0]  exp_r;
  logic        sign_r, zero_sign_r, spec_hit_r;
  logic [31:0] spec_val_r;
  logic [23:0] m24_r;
  logic        g_r, r_r, s_r, zero_r;
  logic [9:0]  nexp_r;
  logic [31:0] res_r;

  logic        sa, sb, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, is_mul, a_big;
  logic        big_s, small_s;
  logic [7:0]  ea, eb, big_e, small_e, diff;
  logic [23:0] ma, mb, big_m, small_m;
  logic [49:0] shifted;
  logic [26:0] aligned;
  logic [27:0] sum;
  logic [47:0] prod, u_mant;
  logic [9:0]  u_exp;
  logic        u_sign, spec_hit;
  logic [31:0] spec_val;
  logic [5:0]  lz;
  logic [46:0] n;
  logic [9:0]  n_exp;
  logic        n_stk;
  logic        round_up;
  logic [24:0] m25;
  logic [9:0]  rexp;
  logic [22:0] rfrac;
  logic [31:0] res_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_valid) state_next = UNPACK;
      UNPACK:  state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand classification, add alignment with G/R/S, and raw product.
  always_comb begin
    sa = a_r[31];
    sb = b_r[31];
    ea = a_r[30:23];
    eb = b_r[30:23];
    zero_a = (ea == 8'd0);
    zero_b = (eb == 8'd0);
    inf_a  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    inf_b  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    nan_a  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    nan_b  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    ma = zero_a ? 24'd0 : {1'b1, a_r[22:0]};
    mb = zero_b ? 24'd0 : {1'b1, b_r[22:0]};
    is_mul = (inst_r == INST_WIDTH'(1));
    a_big   = (a_r[30:0] >= b_r[30:0]);
    big_m   = a_big ? ma : mb;
    small_m = a_big ? mb : ma;
    big_e   = a_big ? ea : eb;
    small_e = a_big ? eb : ea;
    big_s   = a_big ? sa : sb;
    small_s = a_big ? sb : sa;
    diff    = big_e - small_e;
    shifted = {small_m, 26'd0} >> diff;
    if (diff >= 8'd26) aligned = {26'd0, |small_m};
    else               aligned = {shifted[49:24], |shifted[23:0]};
    if (big_s == small_s) sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};
    else                  sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};
    prod = 48'(ma) * 48'(mb);
    // Both paths share one layout: hidden bit at 46, carry/overflow at 47.
    if (is_mul) begin
      u_mant = prod;
      u_exp  = 10'(ea) + 10'(eb) - 10'd127;
      u_sign = sa ^ sb;
    end else begin
      u_mant = {sum, 20'd0};
      u_exp  = 10'(big_e);
      u_sign = big_s;
    end
    spec_hit = 1'b0;
    spec_val = QNAN;
    if (is_mul) begin
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) spec_hit = 1'b1;
      else if (inf_a || inf_b) begin
        spec_hit = 1'b1;
        spec_val = {sa ^ sb, 8'hFF, 23'd0};
      end
    end else begin
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) spec_hit = 1'b1;
      else if (inf_a) begin
        spec_hit = 1'b1;
        spec_val = a_r;
      end else if (inf_b) begin
        spec_hit = 1'b1;
        spec_val = b_r;
      end
    end
  end

  always_comb begin
    lz = '0;
    for (int i = 0; i < 47; i++) if (mant_r[i]) lz = 6'(46 - i);
    if (mant_r[47]) begin
      n     = mant_r[47:1];
      n_exp = exp_r + 10'd1;
      n_stk = mant_r[0];
    end else begin
      n     = mant_r[46:0] << lz;
      n_exp = exp_r - 10'(lz);
      n_stk = 1'b0;
    end
  end

  always_comb begin
    round_up = g_r & (r_r | s_r | m24_r[0]);
    m25      = {1'b0, m24_r} + 25'(round_up);
    rexp     = nexp_r + 10'(m25[24]);
    rfrac    = m25[24] ? m25[23:1] : m25[22:0];
    if (spec_hit_r)                   res_c = spec_val_r;
    else if (zero_r)                  res_c = {zero_sign_r, 31'd0};
    else if ($signed(rexp) >= 10'sd255) res_c = {sign_r, 8'hFF, 23'd0};
    else if ($signed(rexp) <= 10'sd0)   res_c = {sign_r, 31'd0};
    else                              res_c = {sign_r, rexp[7:0], rfrac};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      inst_r      <= '0;
      mant_r      <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      zero_sign_r <= 1'b0;
      spec_hit_r  <= 1'b0;
      spec_val_r  <= '0;
      m24_r       <= '0;
      g_r         <= 1'b0;
      r_r         <= 1'b0;
      s_r         <= 1'b0;
      zero_r      <= 1'b0;
      nexp_r      <= '0;
      res_r       <= '0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      case (state)
        IDLE: if (bus.i_valid) begin
          a_r    <= bus.i_data_a;
          b_r    <= bus.i_data_b;
          inst_r <= bus.i_inst;
        end
        UNPACK: begin
          mant_r      <= u_mant;
          exp_r       <= u_exp;
          sign_r      <= u_sign;
          zero_sign_r <= is_mul ? (sa ^ sb) : (sa & sb);
          spec_hit_r  <= spec_hit;
          spec_val_r  <= spec_val;
        end
        NORM: begin
          m24_r  <= n[46:23];
          g_r    <= n[22];
          r_r    <= n[21];
          s_r    <= (|n[20:0]) | n_stk;
          zero_r <= (mant_r == 48'd0);
          nexp_r <= n_exp;
        end
        ROUND: res_r <= res_c;
        OUT: begin
          bus.o_data  <= res_r;
          bus.o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_EXC_FLAGS_EN
  logic       f_ovf, f_unf, f_inx;
  logic [3:0] flags_r;

  always_comb begin
    f_ovf = !spec_hit_r && !zero_r && ($signed(rexp) >= 10'sd255);
    f_unf = !spec_hit_r && !zero_r && ($signed(rexp) <= 10'sd0);
    f_inx = (!spec_hit_r && !zero_r && (g_r | r_r | s_r)) | f_ovf | f_unf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flags_r     <= '0;
      bus.o_flags <= '0;
    end else begin
      if (state == ROUND) flags_r <= {res_c == QNAN, f_ovf, f_unf, f_inx};
      if (state == OUT)   bus.o_flags <= flags_r;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_mc.sv
// tb_fpu_mc: directed-vector bench for fpu_mc covering latency, rounding, specials,
// dropped requests while busy, and reset in the middle of an operation.
module tb_fpu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        inst;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[19];

  fpu_mc_if #(.DATA_WIDTH(32), .INST_WIDTH(1)) bus ();

  fpu_mc #(.DATA_WIDTH(32), .INST_WIDTH(1)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one request so that it is sampled on the next rising edge; returns #1 after it.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic inst);
    @(negedge clk);
    bus.i_data_a = a;
    bus.i_data_b = b;
    bus.i_inst   = inst;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid  = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    apply_stimulus(v.a, v.b, v.inst);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) lat = k;
    end
    check_output({name, "/latency"}, 32'(lat), 32'd4);
    check_output({name, "/data"}, bus.o_data, v.want);
    @(posedge clk);
    #1;
    check_output({name, "/pulse"}, {31'd0, bus.o_valid}, 32'd0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] seen;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1]  = '{32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vecs[4]  = '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000};
    vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000};
    vecs[8]  = '{32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000};
    vecs[9]  = '{32'hC0000000, 32'h40400000, 1'b1, 32'hC0C00000};
    vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000};
    vecs[12] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
    vecs[13] = '{32'h00000000, 32'hC0400000, 1'b1, 32'h80000000};
    vecs[14] = '{32'h00800000, 32'h00800000, 1'b1, 32'h00000000};
    vecs[15] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000};
    vecs[16] = '{32'hFF800000, 32'hC0000000, 1'b1, 32'h7F800000};
    vecs[17] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[18] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};

    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_inst   = '0;
    bus.i_valid  = 1'b0;
    #1 rst_n = 1'b0;
    #5;
    check_output("reset/o_valid", {31'd0, bus.o_valid}, 32'd0);
    check_output("reset/o_data", bus.o_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 19; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // A second strobe two edges into an operation must be dropped silently.
    apply_stimulus(32'h3F800000, 32'h40000000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.i_data_a = 32'h40000000;
    bus.i_data_b = 32'h40000000;
    bus.i_inst   = 1'b1;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid  = 1'b0;
    pulses = 0;
    seen   = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) begin
        pulses++;
        seen = bus.o_data;
      end
    end
    check_output("busy/pulses", 32'(pulses), 32'd1);
    check_output("busy/data", seen, 32'h40400000);
    run_vec("busy/next", vecs[9]);

    // Reset while the operation sits in NORM aborts it without a result.
    apply_stimulus(32'h3FC00000, 32'h40000000, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset/o_valid", {31'd0, bus.o_valid}, 32'd0);
    check_output("midreset/o_data", bus.o_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) pulses++;
    end
    check_output("midreset/no_result", 32'(pulses), 32'd0);
    run_vec("after_reset", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
